i2c_target_regs: RTL and testbench

I2C target (slave) that responds to a 7-bit address and exposes a simple byte-wide register port with an auto-incrementing register pointer. It is the responder end of the bus driven by the team's I2C master. It stands in for the IMU in simulation and bench loop-back, and lets the FPGA present a register map to an external controller. It supports standard register-pointer transactions: pointer write, burst write, and repeated-START burst read.

---
 rtl/i2c_target_regs.sv | 158 +++++++++++++++
 tb/tb_i2c_target_regs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target at TARGET_ADDR exposing a byte-wide register port
// with an auto-incrementing, transaction-persistent register pointer.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h28
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SCL,
  input  logic       i_SDA,
  output logic       o_SDA_OE,
  output logic [7:0] o_Reg_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Wr_En,
  output logic       o_Rd_Req,
  input  logic [7:0] i_Rd_Data,
  output logic       o_Busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, IGNORE, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
  } state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, ptr_q, ptr_d, wdata_q, wdata_d;
  logic oe_q, oe_d, wr_en_q, wr_en_d, rd_req_q, rd_req_d;
  logic busy_q, busy_d, rw_q, rw_d, ptr_set_q, ptr_set_d;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx_byte;
  // bit [1] is the synchronized pin, bit [2] its one-cycle history
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_c   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rx_byte  = {sr_q[6:0], sda_q[1]};
  assign o_SDA_OE   = oe_q;
  assign o_Reg_Addr = ptr_q;
  assign o_Wr_Data  = wdata_q;
  assign o_Wr_En    = wr_en_q;
  assign o_Rd_Req   = rd_req_q;
  assign o_Busy     = busy_q;
  always_comb begin
    scl_d     = {scl_q[1:0], i_SCL};
    sda_d     = {sda_q[1:0], i_SDA};
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = rd_req_q ? i_Rd_Data : sr_q;
    ptr_d     = (wr_en_q || rd_req_q) ? ptr_q + 8'd1 : ptr_q;
    wdata_d   = wdata_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    rd_req_d  = 1'b0;
    busy_d    = busy_q;
    rw_d      = rw_q;
    ptr_set_d = ptr_set_q;
    if (stop_c) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      ptr_set_d = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_BYTE: begin
          if (scl_rise) begin
            sr_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7 && state_q == ADDR) begin
              state_d = (rx_byte[7:1] == TARGET_ADDR) ? ADDR : IGNORE;
              busy_d  = busy_q | (rx_byte[7:1] == TARGET_ADDR);
              rw_d    = rx_byte[0];
            end
            if (cnt_q == 4'd7 && state_q == PTR) begin
              ptr_d     = rx_byte;
              ptr_set_d = 1'b1;
            end
            if (cnt_q == 4'd7 && state_q == WR_BYTE) begin
              wdata_d = rx_byte;
              wr_en_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : (state_q == PTR) ? PTR_ACK : WR_ACK;
            oe_d    = 1'b1;
            cnt_d   = 4'd0;
          end
        end
        ADDR_ACK: begin
          rd_req_d = scl_rise & rw_q;
          if (scl_fall) begin
            state_d = rw_q ? RD_BYTE : ptr_set_q ? WR_BYTE : PTR;
            oe_d    = rw_q & ~sr_q[7];
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_BYTE;
            oe_d    = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall && cnt_q == 4'd8) begin
            state_d = RD_ACK;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
          end else if (scl_fall) begin
            sr_d = {sr_q[6:0], 1'b0};
            oe_d = ~sr_q[6];
          end
        end
        RD_ACK: begin
          // controller NACK ends the read burst; ACK fetches the next register
          if (scl_rise) begin
            state_d  = sda_q[1] ? IGNORE : RD_ACK;
            rd_req_d = ~sda_q[1];
          end else if (scl_fall) begin
            state_d = RD_BYTE;
            oe_d    = ~sr_q[7];
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      ptr_q     <= 8'h00;
      wdata_q   <= 8'h00;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      ptr_set_q <= 1'b0;
    end else begin
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      rd_req_q  <= rd_req_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      ptr_set_q <= ptr_set_d;
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level controller driving i2c_target_regs, with a register-map
// reference model and a strobe scoreboard checked by an independent monitor.
module tb_i2c_target_regs;
  localparam int Q = 8;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_drv = 1'b1;
  logic oe, wr_en, rd_req, busy, sda_bus;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic [7:0] regs [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr = 8'h00;
  logic [15:0] exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [15:0] we;
  logic [7:0] re;
  logic prev_strobe = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign sda_bus = sda_drv & ~oe;
  assign rd_data = regs[reg_addr];

  i2c_target_regs #(.TARGET_ADDR(7'h28)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_SCL(scl), .i_SDA(sda_bus), .o_SDA_OE(oe),
    .o_Reg_Addr(reg_addr), .o_Wr_Data(wr_data), .o_Wr_En(wr_en),
    .o_Rd_Req(rd_req), .i_Rd_Data(rd_data), .o_Busy(busy)
  );

  task automatic chk(input string n, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, want);
    end
  endtask

  // register file behind the target
  always @(posedge clk) if (wr_en) regs[reg_addr] = wr_data;

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected got_addr=%0h got_data=%0h want=none", reg_addr, wr_data);
      end else begin
        we = exp_wr.pop_front();
        chk("wr_addr", reg_addr, we[15:8]);
        chk("wr_data", wr_data, we[7:0]);
      end
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected got_addr=%0h want=none", reg_addr);
      end else begin
        re = exp_rd.pop_front();
        chk("rd_addr", reg_addr, re);
      end
    end
    if (wr_en || rd_req) chk("strobe_spacing", {wr_en & rd_req, prev_strobe}, 0);
    prev_strobe = wr_en | rd_req;
  end

  task automatic q();
    repeat (Q) @(posedge clk);
  endtask
  task automatic bstart();
    sda_drv = 1'b1; q(); scl = 1'b1; q(); sda_drv = 1'b0; q(); scl = 1'b0; q();
  endtask
  task automatic bstop();
    sda_drv = 1'b0; q(); scl = 1'b1; q(); sda_drv = 1'b1; q();
  endtask
  task automatic wbit(input logic b);
    sda_drv = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask
  task automatic rbit(output logic b);
    sda_drv = 1'b1; q(); scl = 1'b1; q(); #1 b = sda_bus; q(); scl = 1'b0; q();
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack);
  endtask

  task automatic tx_write(input logic [7:0] p, input logic [7:0] ds [$]);
    logic a;
    bstart();
    wbyte(8'h50, a); chk("wr_addr_ack", a, 0); chk("wr_busy", busy, 1);
    wbyte(p, a); chk("ptr_ack", a, 0);
    ref_ptr = p;
    foreach (ds[i]) begin
      exp_wr.push_back({ref_ptr, ds[i]});
      ref_mem[ref_ptr] = ds[i];
      ref_ptr++;
      wbyte(ds[i], a); chk("data_ack", a, 0);
    end
    bstop(); q();
    chk("wr_busy_after_stop", busy, 0);
    chk("wr_ptr_after", reg_addr, ref_ptr);
  endtask

  task automatic tx_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d, want;
    if (set_ptr) begin
      bstart();
      wbyte(8'h50, a); chk("rdp_addr_ack", a, 0);
      wbyte(p, a); chk("rdp_ptr_ack", a, 0);
      ref_ptr = p;
    end
    bstart();
    exp_rd.push_back(ref_ptr);
    wbyte(8'h51, a); chk("rd_addr_ack", a, 0); chk("rd_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      want = ref_mem[ref_ptr];
      ref_ptr++;
      if (i < n - 1) exp_rd.push_back(ref_ptr);
      rbyte(d, i == n - 1);
      chk("rd_byte", d, want);
    end
    chk("rd_sda_released", oe, 0);
    bstop(); q();
    chk("rd_busy_after_stop", busy, 0);
    chk("rd_ptr_after", reg_addr, ref_ptr);
  endtask

  task automatic tx_miss(input logic [7:0] ab, input int extra);
    logic a;
    bstart();
    wbyte(ab, a); chk("miss_nack", a, 1); chk("miss_busy", busy, 0);
    for (int i = 0; i < extra; i++) begin
      wbyte(8'($urandom), a); chk("miss_data_nack", a, 1);
    end
    bstop(); q();
    chk("miss_busy_after", busy, 0);
    chk("miss_ptr", reg_addr, ref_ptr);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ds [$];
    logic [7:0] v, b51;
    logic [6:0] ma;
    logic a;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      regs[i] = v;
      ref_mem[i] = v;
    end
    regs[8'h1A] = 8'hA5; ref_mem[8'h1A] = 8'hA5;
    regs[8'h1B] = 8'h3C; ref_mem[8'h1B] = 8'h3C;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_oe", oe, 0); chk("rst_ptr", reg_addr, 0); chk("rst_wdata", wr_data, 0);
    chk("rst_wr_en", wr_en, 0); chk("rst_rd_req", rd_req, 0); chk("rst_busy", busy, 0);

    ds = {8'h0C};
    tx_write(8'h3D, ds);
    ds = {8'h11, 8'h22, 8'h33};
    tx_write(8'hFE, ds);
    chk("wrap_ptr", reg_addr, 8'h01);
    tx_read(1'b1, 8'h1A, 2);
    tx_miss(8'h52, 1);
    ds = {8'h77};
    tx_write(8'h10, ds);

    // STOP after 4 bits of a data byte
    bstart();
    wbyte(8'h50, a); chk("mid_addr_ack", a, 0);
    wbyte(8'h40, a); chk("mid_ptr_ack", a, 0);
    ref_ptr = 8'h40;
    for (int i = 0; i < 4; i++) wbit(1'($urandom));
    bstop(); q();
    chk("mid_oe", oe, 0); chk("mid_busy", busy, 0); chk("mid_ptr", reg_addr, 8'h40);
    tx_read(1'b0, 8'h00, 1);

    // reset while the address ACK of a read is being driven
    b51 = 8'h51;
    bstart();
    for (int i = 7; i >= 0; i--) wbit(b51[i]);
    chk("pre_rst_oe", oe, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_oe", oe, 0); chk("mrst_ptr", reg_addr, 0); chk("mrst_wdata", wr_data, 0);
    chk("mrst_wr_en", wr_en, 0); chk("mrst_rd_req", rd_req, 0); chk("mrst_busy", busy, 0);
    ref_ptr = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bstop(); q();
    tx_read(1'b0, 8'h00, 2);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          ds = {};
          for (int i = 0; i < int'($urandom_range(1, 4)); i++) ds.push_back(8'($urandom));
          tx_write(8'($urandom), ds);
        end
        1: tx_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
        default: begin
          ma = 7'($urandom);
          if (ma == 7'h28) ma = 7'h29;
          tx_miss({ma, 1'($urandom)}, int'($urandom_range(0, 2)));
        end
      endcase
    end

    repeat (10) @(posedge clk);
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
